// File: rtl/char_entry_ctrl.sv
// ============================================================================
//  Module   : char_entry_ctrl
//  Function : push-button front end for the four-digit seven-segment driver:
//             debounced segment editing, 4-character buffer and mode select.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module char_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic        btnC,
    input  logic        btnR,
    input  logic        btnU,
    input  logic        btnD,
    input  logic        btnL,
    output logic [31:0] characters,
    output logic [7:0]  loadedChar,
    output logic [7:0]  seg,
    output logic [2:0]  State,
    output logic [7:0]  cursor_led,
    output logic [2:0]  char_count
);

    typedef enum logic [2:0] {
        MODE_SHOW = 3'b000,
        MODE_EDIT = 3'b110,
        MODE_LAST = 3'b111
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit order: [4]=L [3]=D [2]=U [1]=C [0]=R
    logic [4:0] raw_btn;
    logic [4:0] press;

    assign raw_btn = {btnL, btnD, btnU, btnC, btnR};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_btn
            logic             sync1;
            logic             sync2;
            logic             stable;
            logic             pulse;
            logic [CNT_W-1:0] cnt;

            always_ff @(posedge clock_100Mhz or posedge reset) begin
                if (reset) begin
                    sync1  <= 1'b0;
                    sync2  <= 1'b0;
                    stable <= 1'b0;
                    pulse  <= 1'b0;
                    cnt    <= '0;
                end else begin
                    sync1 <= raw_btn[gi];
                    sync2 <= sync1;
                    pulse <= 1'b0;
                    if (sync2 != stable) begin
                        if (cnt == CNT_LAST) begin
                            stable <= sync2;
                            cnt    <= '0;
                            pulse  <= sync2;   // only accepted rises are events
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
            end

            assign press[gi] = pulse;
        end
    endgenerate

    mode_t       mode, mode_next;
    logic [31:0] chars_next;
    logic [7:0]  loaded_next;
    logic [7:0]  seg_next;
    logic [2:0]  cursor, cursor_next;
    logic [2:0]  count_next;

    logic do_mode, do_del, do_load, do_tog, do_adv, in_edit;

    assign in_edit = (mode == MODE_EDIT);

    // One action per cycle; lower-priority pulses are dropped.
    assign do_mode = press[4];
    assign do_del  = press[3] & ~press[4];
    assign do_load = press[2] & ~|press[4:3] & in_edit;
    assign do_tog  = press[1] & ~|press[4:2] & in_edit;
    assign do_adv  = press[0] & ~|press[4:1] & in_edit;

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            mode <= MODE_EDIT;
        end else begin
            mode <= mode_next;
        end
    end

    always_comb begin
        mode_next = mode;
        if (do_mode) begin
            case (mode)
                MODE_EDIT: mode_next = MODE_LAST;
                MODE_LAST: mode_next = MODE_SHOW;
                MODE_SHOW: mode_next = MODE_EDIT;
                default:   mode_next = MODE_EDIT;
            endcase
        end
    end

    always_comb begin
        chars_next  = characters;
        loaded_next = loadedChar;
        seg_next    = seg;
        cursor_next = cursor;
        count_next  = char_count;
        if (do_del) begin
            if (char_count != 3'd0) begin
                chars_next  = {8'hFF, characters[31:8]};
                count_next  = char_count - 3'd1;
                loaded_next = (char_count > 3'd1) ? characters[15:8] : 8'hFF;
            end
        end else if (do_load) begin
            chars_next  = {characters[23:0], seg};
            loaded_next = seg;
            count_next  = (char_count >= 3'd4) ? 3'd4 : char_count + 3'd1;
            seg_next    = 8'hFF;
            cursor_next = 3'd0;
        end else if (do_tog) begin
            seg_next[cursor] = ~seg[cursor];
        end else if (do_adv) begin
            cursor_next = cursor + 3'd1;
        end
    end

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            characters <= 32'hFFFF_FFFF;
            loadedChar <= 8'hFF;
            seg        <= 8'hFF;
            cursor     <= 3'd0;
            char_count <= 3'd0;
        end else begin
            characters <= chars_next;
            loadedChar <= loaded_next;
            seg        <= seg_next;
            cursor     <= cursor_next;
            char_count <= count_next;
        end
    end

    assign State      = mode;
    assign cursor_led = 8'd1 << cursor;

endmodule

`default_nettype wire

// File: tb/tb_char_entry_ctrl.sv
// ============================================================================
//  Module   : tb_char_entry_ctrl
//  Function : directed vector bench for char_entry_ctrl (DEBOUNCE_CYCLES = 4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_char_entry_ctrl;

    localparam logic [4:0] B_R = 5'b00001;
    localparam logic [4:0] B_C = 5'b00010;
    localparam logic [4:0] B_U = 5'b00100;
    localparam logic [4:0] B_D = 5'b01000;
    localparam logic [4:0] B_L = 5'b10000;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  btns;
    logic [31:0] characters;
    logic [7:0]  loadedChar;
    logic [7:0]  seg;
    logic [2:0]  State;
    logic [7:0]  cursor_led;
    logic [2:0]  char_count;

    int vectors = 0;
    int fails   = 0;

    typedef struct {
        logic [4:0]  btns;
        logic [31:0] chars;
        logic [7:0]  loaded;
        logic [7:0]  seg;
        logic [2:0]  state;
        logic [7:0]  led;
        logic [2:0]  cnt;
    } vec_t;

    vec_t tbl [22];

    char_entry_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clock_100Mhz (clk),
        .reset        (reset),
        .btnC         (btns[1]),
        .btnR         (btns[0]),
        .btnU         (btns[2]),
        .btnD         (btns[3]),
        .btnL         (btns[4]),
        .characters   (characters),
        .loadedChar   (loadedChar),
        .seg          (seg),
        .State        (State),
        .cursor_led   (cursor_led),
        .char_count   (char_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] mask, input int hold);
        btns = mask;
        repeat (hold) tick();
        btns = 5'b0;
        repeat (10) tick();
    endtask

    task automatic do_reset;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic check(input string name, input logic [31:0] ec, input logic [7:0] el,
                         input logic [7:0] es, input logic [2:0] est, input logic [7:0] eled,
                         input logic [2:0] ecnt);
        vectors++;
        if ({characters, loadedChar, seg, State, cursor_led, char_count} !==
            {ec, el, es, est, eled, ecnt}) begin
            fails++;
            $display("FAIL %s: got chars=%h loaded=%h seg=%h state=%b led=%h cnt=%0d, expected chars=%h loaded=%h seg=%h state=%b led=%h cnt=%0d",
                     name, characters, loadedChar, seg, State, cursor_led, char_count,
                     ec, el, es, est, eled, ecnt);
        end
    endtask

    logic [31:0] m_chars;
    logic [7:0]  m_loaded;
    logic [2:0]  m_cnt;
    logic [7:0]  pats [5];
    int          n;

    initial begin
        tbl[0]  = '{B_C,             32'hFFFFFFFF, 8'hFF, 8'hFE, 3'b110, 8'h01, 3'd0};
        tbl[1]  = '{B_R,             32'hFFFFFFFF, 8'hFF, 8'hFE, 3'b110, 8'h02, 3'd0};
        tbl[2]  = '{B_R,             32'hFFFFFFFF, 8'hFF, 8'hFE, 3'b110, 8'h04, 3'd0};
        tbl[3]  = '{B_C,             32'hFFFFFFFF, 8'hFF, 8'hFA, 3'b110, 8'h04, 3'd0};
        tbl[4]  = '{B_U,             32'hFFFFFFFA, 8'hFA, 8'hFF, 3'b110, 8'h01, 3'd1};
        tbl[5]  = '{B_C,             32'hFFFFFFFA, 8'hFA, 8'hFE, 3'b110, 8'h01, 3'd1};
        tbl[6]  = '{B_R,             32'hFFFFFFFA, 8'hFA, 8'hFE, 3'b110, 8'h02, 3'd1};
        tbl[7]  = '{B_L,             32'hFFFFFFFA, 8'hFA, 8'hFE, 3'b111, 8'h02, 3'd1};
        tbl[8]  = '{B_U,             32'hFFFFFFFA, 8'hFA, 8'hFE, 3'b111, 8'h02, 3'd1};
        tbl[9]  = '{B_L,             32'hFFFFFFFA, 8'hFA, 8'hFE, 3'b000, 8'h02, 3'd1};
        tbl[10] = '{B_C,             32'hFFFFFFFA, 8'hFA, 8'hFE, 3'b000, 8'h02, 3'd1};
        tbl[11] = '{B_U,             32'hFFFFFFFA, 8'hFA, 8'hFE, 3'b000, 8'h02, 3'd1};
        tbl[12] = '{B_R,             32'hFFFFFFFA, 8'hFA, 8'hFE, 3'b000, 8'h02, 3'd1};
        tbl[13] = '{B_D,             32'hFFFFFFFF, 8'hFF, 8'hFE, 3'b000, 8'h02, 3'd0};
        tbl[14] = '{B_D,             32'hFFFFFFFF, 8'hFF, 8'hFE, 3'b000, 8'h02, 3'd0};
        tbl[15] = '{B_L,             32'hFFFFFFFF, 8'hFF, 8'hFE, 3'b110, 8'h02, 3'd0};
        tbl[16] = '{B_L | B_U,       32'hFFFFFFFF, 8'hFF, 8'hFE, 3'b111, 8'h02, 3'd0};
        tbl[17] = '{B_L,             32'hFFFFFFFF, 8'hFF, 8'hFE, 3'b000, 8'h02, 3'd0};
        tbl[18] = '{B_L,             32'hFFFFFFFF, 8'hFF, 8'hFE, 3'b110, 8'h02, 3'd0};
        tbl[19] = '{B_D | B_C,       32'hFFFFFFFF, 8'hFF, 8'hFE, 3'b110, 8'h02, 3'd0};
        tbl[20] = '{B_U | B_C | B_R, 32'hFFFFFFFE, 8'hFE, 8'hFF, 3'b110, 8'h01, 3'd1};
        tbl[21] = '{B_C | B_R,       32'hFFFFFFFE, 8'hFE, 8'hFE, 3'b110, 8'h01, 3'd1};

        pats[0] = 8'h01; pats[1] = 8'h02; pats[2] = 8'h03; pats[3] = 8'h04; pats[4] = 8'h05;

        reset = 1'b1;
        btns  = 5'b0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (20) tick();
        check("reset_idle", 32'hFFFFFFFF, 8'hFF, 8'hFF, 3'b110, 8'h01, 3'd0);

        for (int i = 0; i < 22; i++) begin
            press(tbl[i].btns, 10);
            check($sformatf("vec%0d", i), tbl[i].chars, tbl[i].loaded, tbl[i].seg,
                  tbl[i].state, tbl[i].led, tbl[i].cnt);
        end

        // Five loads through a full buffer, then deletes past empty.
        do_reset();
        m_chars = 32'hFFFFFFFF; m_loaded = 8'hFF; m_cnt = 3'd0;
        for (int k = 0; k < 5; k++) begin
            for (int b = 0; b < 8; b++) begin
                if (pats[k][b] == 1'b0) press(B_C, 8);
                press(B_R, 8);
            end
            check($sformatf("enter%0d", k), m_chars, m_loaded, pats[k], 3'b110, 8'h01, m_cnt);
            press(B_U, 8);
            m_chars  = {m_chars[23:0], pats[k]};
            m_loaded = pats[k];
            m_cnt    = (m_cnt == 3'd4) ? 3'd4 : m_cnt + 3'd1;
            check($sformatf("load%0d", k), m_chars, m_loaded, 8'hFF, 3'b110, 8'h01, m_cnt);
        end
        press(B_D, 8);
        check("del1", 32'hFF020304, 8'h04, 8'hFF, 3'b110, 8'h01, 3'd3);
        press(B_D, 8);
        check("del2", 32'hFFFF0203, 8'h03, 8'hFF, 3'b110, 8'h01, 3'd2);
        press(B_D, 8);
        check("del3", 32'hFFFFFF02, 8'h02, 8'hFF, 3'b110, 8'h01, 3'd1);
        for (int k = 4; k <= 7; k++) begin
            press(B_D, 8);
            check($sformatf("del%0d", k), 32'hFFFFFFFF, 8'hFF, 8'hFF, 3'b110, 8'h01, 3'd0);
        end

        // Short pulses and bouncing: only the final stable hold counts.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            btns = B_C; repeat (3) tick();
            btns = 5'b0; repeat (3) tick();
        end
        repeat (10) tick();
        check("short_pulses", 32'hFFFFFFFF, 8'hFF, 8'hFF, 3'b110, 8'h01, 3'd0);
        for (int k = 0; k < 8; k++) begin
            btns = (k % 2 == 0) ? B_C : 5'b0;
            tick();
        end
        press(B_C, 10);
        check("bounce", 32'hFFFFFFFF, 8'hFF, 8'hFE, 3'b110, 8'h01, 3'd0);

        // Latency from a clean raw rise to the registered output.
        do_reset();
        btns = B_C;
        n = 0;
        while (seg === 8'hFF && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (n < 6 || n > 8) begin
            fails++;
            $display("FAIL latency: got %0d edges, expected 6..8", n);
        end
        btns = 5'b0;
        repeat (10) tick();

        // Reset during debounce, and a button held across reset release.
        press(B_L, 8);
        btns = B_C;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("reset_async", 32'hFFFFFFFF, 8'hFF, 8'hFF, 3'b110, 8'h01, 3'd0);
        repeat (2) tick();
        reset = 1'b0;
        btns  = 5'b0;
        repeat (12) tick();
        check("reset_mid", 32'hFFFFFFFF, 8'hFF, 8'hFF, 3'b110, 8'h01, 3'd0);
        btns = B_C;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        press(B_C, 10);
        check("held_thru_reset", 32'hFFFFFFFF, 8'hFF, 8'hFE, 3'b110, 8'h01, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

`default_nettype wire
